// File: rtl/debounce_timer_arbiter_if.sv
// Channel bundle for debounce_timer_arbiter.
// Optional feature macro: FALL_PULSE_EN adds the CH_FALL falling-commit pulse.
//
// Handshake semantics: there is no valid/ready pair on this bundle. CH_IN is
// a free-running raw level that the slave resynchronises. All slave outputs
// are registered and valid every cycle after reset release. CH_PULSE and
// CH_FALL are single-cycle strobes.
interface debounce_timer_arbiter_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] CH_IN;
  logic [N_CH-1:0] CH_STABLE;
  logic [N_CH-1:0] CH_PULSE;
  logic [N_CH-1:0] GRANT;
  logic            BUSY;
  logic [1:0]      STATE;   // debug view of the arbiter FSM
`ifdef FALL_PULSE_EN
  logic [N_CH-1:0] CH_FALL;

  modport master (output CH_IN, input CH_STABLE, input CH_PULSE, input GRANT,
                  input BUSY, input STATE, input CH_FALL);
  modport slave  (input CH_IN, output CH_STABLE, output CH_PULSE, output GRANT,
                  output BUSY, output STATE, output CH_FALL);
`else
  modport master (output CH_IN, input CH_STABLE, input CH_PULSE, input GRANT,
                  input BUSY, input STATE);
  modport slave  (input CH_IN, output CH_STABLE, output CH_PULSE, output GRANT,
                  output BUSY, output STATE);
`endif
endinterface

// File: rtl/debounce_timer_arbiter.sv
// Multi-channel debouncer sharing one settle timer between N_CH channels.
// A round-robin arbiter hands the timer to one changed channel at a time.
// The new level is committed only if it holds for SETTLE_CYC cycles.
// Optional feature macro: FALL_PULSE_EN (CH_FALL pulse on committed 1->0).
module debounce_timer_arbiter #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 20,
  parameter int SETTLE_CYC = 1000000
) (
  input  logic                     CLK,
  input  logic                     RESET,
  debounce_timer_arbiter_if.slave  bus
);

  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CNT_W-1:0] TERM    = CNT_W'(SETTLE_CYC - 1);
  localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(N_CH - 1);
  localparam logic [N_CH-1:0]  ONE_HOT = N_CH'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARB    = 2'd1,
    COUNT  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t          state;
  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] sync2;
  logic [N_CH-1:0] stable;
  logic [N_CH-1:0] pulse;
  logic [N_CH-1:0] grant;
  logic            busy;
  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gidx;
`ifdef FALL_PULSE_EN
  logic [N_CH-1:0] fall;
`endif

  logic [N_CH-1:0]  req;
  logic             found;
  logic [PTR_W-1:0] pick;
  logic [PTR_W-1:0] nxt_ptr;

  // A channel requests the timer whenever its synchronised level differs
  // from its committed level.
  assign req = sync2 ^ stable;

  // Pointer advances past the channel just served, wrapping at N_CH.
  assign nxt_ptr = (gidx == LAST_CH) ? '0 : gidx + 1'b1;

  // Round-robin search: first requesting channel starting at ptr.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = PTR_W'(idx);
      end
    end
  end

  // Synchronizers, arbiter FSM, shared settle counter and registered outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state  <= IDLE;
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      pulse  <= '0;
      grant  <= '0;
      busy   <= 1'b0;
      cnt    <= '0;
      ptr    <= '0;
      gidx   <= '0;
`ifdef FALL_PULSE_EN
      fall   <= '0;
`endif
    end else begin
      sync1 <= bus.CH_IN;
      sync2 <= sync1;
      pulse <= '0;
`ifdef FALL_PULSE_EN
      fall  <= '0;
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            state <= ARB;
            busy  <= 1'b1;
          end
        end
        ARB: begin
          if (found) begin
            grant <= ONE_HOT << pick;
            gidx  <= pick;
            cnt   <= '0;
            state <= COUNT;
          end else begin
            // Every request bounced away before it could be served.
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        COUNT: begin
          if (sync2[gidx] == stable[gidx]) begin
            // Bounce back: drop the grant, keep the committed level.
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= nxt_ptr;
            state <= IDLE;
          end else if (cnt == TERM) begin
            state <= COMMIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        COMMIT: begin
          stable[gidx] <= sync2[gidx];
          // Strobe only on a real level change of the granted channel.
          if (sync2[gidx] != stable[gidx]) begin
            if (sync2[gidx]) begin
              pulse[gidx] <= 1'b1;
            end
`ifdef FALL_PULSE_EN
            else begin
              fall[gidx] <= 1'b1;
            end
`endif
          end
          ptr   <= nxt_ptr;
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.CH_STABLE = stable;
  assign bus.CH_PULSE  = pulse;
  assign bus.GRANT     = grant;
  assign bus.BUSY      = busy;
  assign bus.STATE     = state;
`ifdef FALL_PULSE_EN
  assign bus.CH_FALL   = fall;
`endif

endmodule
